instr_fetch: RTL and testbench

Fetch/pre-decode stage sitting directly downstream of the instruction ROM and upstream of the execute stage of the 16-bit minesweeper CPU. It owns the PC and drives the ROM byte address. It reads the combinational ROM word and folds unconditional JUMPs locally. It presents each remaining instruction, with its decoded fields, through a valid/ready output register. Taken-branch redirects from execute flush the stage.

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch / pre-decode stage of the 16-bit minesweeper CPU. Owns the PC and
//   drives the ROM byte address. Unconditional JUMPs are folded locally: they
//   redirect the PC and are never handed to execute. Every other instruction is
//   registered with its PC and presented through a valid/ready output register.
//   A taken branch from execute flushes the stage and clears HALT.
//
// Ports
//   CLK, RESET     clock, synchronous active-high reset
//   IMEM_ADDR      ROM byte address (always equals the PC)
//   IMEM_Q         combinational ROM word at IMEM_ADDR
//   BR_TAKEN       redirect strobe from execute
//   BR_TARGET      redirect byte address (bit 0 ignored)
//   OUT_VALID      output register holds an instruction
//   OUT_READY      execute accepts the instruction this cycle
//   OUT_INSTR      raw instruction word
//   OUT_PC         byte address of OUT_INSTR
//   OUT_OPCODE/RS/RT/RD/FUNCT  field slices of OUT_INSTR
//   OUT_IMM        sign-extended OUT_INSTR[5:0]
//   HALT           fetch stopped (self-jump or opcode 0000)
//   ISSUE_COUNT    number of accepted instructions, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [DATA_W-1:0] IMEM_Q,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_INSTR,
    output logic [ADDR_W-1:0] OUT_PC,
    output logic [3:0]        OUT_OPCODE,
    output logic [2:0]        OUT_RS,
    output logic [2:0]        OUT_RT,
    output logic [2:0]        OUT_RD,
    output logic [2:0]        OUT_FUNCT,
    output logic [15:0]       OUT_IMM,
    output logic              HALT,
    output logic [15:0]       ISSUE_COUNT
);

    localparam logic [3:0] OP_STOP = 4'h0;
    localparam logic [3:0] OP_JUMP = 4'h1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              halt_q, halt_d;
    logic [15:0]       issue_cnt_q, issue_cnt_d;

    logic              load;
    logic [3:0]        fop;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              unused;

    // The output register can take a new word when empty or being drained,
    // and only while fetch is running.
    assign load    = (~out_valid_q | OUT_READY) & ~halt_q;
    assign fop     = IMEM_Q[DATA_W-1:DATA_W-4];
    // JUMP carries a word index; shift it to a byte address.
    assign jmp_tgt = {IMEM_Q[ADDR_W-2:0], 1'b0};

    // Upper target bits of a JUMP must be zero and the branch LSB is dropped.
    assign unused  = ^{BR_TARGET[0], IMEM_Q[11:ADDR_W-1]};

    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        halt_d      = halt_q;
        issue_cnt_d = issue_cnt_q;

        if (BR_TAKEN) begin
            // Redirect wins over everything; any held instruction is dropped.
            pc_d        = {BR_TARGET[ADDR_W-1:1], 1'b0};
            out_valid_d = 1'b0;
            halt_d      = 1'b0;
        end else if (load) begin
            if (fop == OP_JUMP) begin
                // A jump to itself can never make progress: stop fetching.
                if (jmp_tgt == pc_q) begin
                    halt_d = 1'b1;
                end else begin
                    pc_d = jmp_tgt;
                end
                out_valid_d = 1'b0;
            end else if (fop == OP_STOP) begin
                halt_d      = 1'b1;
                out_valid_d = 1'b0;
            end else begin
                out_instr_d = IMEM_Q;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + ADDR_W'(2);
            end
        end else if (out_valid_q & OUT_READY) begin
            // Halted: let the pending instruction drain without refilling.
            out_valid_d = 1'b0;
        end

        // Acceptance is counted even when a redirect flushes in the same cycle.
        if (out_valid_q & OUT_READY & ~(&issue_cnt_q)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halt_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halt_q      <= halt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign IMEM_ADDR   = pc_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_INSTR   = out_instr_q;
    assign OUT_PC      = out_pc_q;
    assign HALT        = halt_q;
    assign ISSUE_COUNT = issue_cnt_q;

    assign OUT_OPCODE  = out_instr_q[15:12];
    assign OUT_RS      = out_instr_q[11:9];
    assign OUT_RT      = out_instr_q[8:6];
    assign OUT_RD      = out_instr_q[5:3];
    assign OUT_FUNCT   = out_instr_q[2:0];
    assign OUT_IMM     = {{10{out_instr_q[5]}}, out_instr_q[5:0]};

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  IMEM_ADDR;
    logic [15:0] IMEM_Q;
    logic        BR_TAKEN = 1'b0;
    logic [9:0]  BR_TARGET = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_INSTR;
    logic [9:0]  OUT_PC;
    logic [3:0]  OUT_OPCODE;
    logic [2:0]  OUT_RS, OUT_RT, OUT_RD, OUT_FUNCT;
    logic [15:0] OUT_IMM;
    logic        HALT;
    logic [15:0] ISSUE_COUNT;

    logic [15:0] rom [0:511];
    assign IMEM_Q = rom[IMEM_ADDR[9:1]];

    int total = 0;
    int bad = 0;

    instr_fetch #(.ADDR_W(10), .DATA_W(16), .RESET_PC(10'h000)) dut (
        .CLK(CLK), .RESET(RESET), .IMEM_ADDR(IMEM_ADDR), .IMEM_Q(IMEM_Q),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
        .OUT_OPCODE(OUT_OPCODE), .OUT_RS(OUT_RS), .OUT_RT(OUT_RT), .OUT_RD(OUT_RD),
        .OUT_FUNCT(OUT_FUNCT), .OUT_IMM(OUT_IMM), .HALT(HALT), .ISSUE_COUNT(ISSUE_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // sel 0: directed program, 1: plain fill, 2: random forward-jump program
    task automatic load_rom(input int sel);
        for (int i = 0; i < 512; i++) rom[i] = 16'h2000 | 16'(i);
        if (sel == 0) begin
            rom[0]    = 16'hF008;
            rom[1]    = 16'h5101;
            rom[2]    = 16'h51FF;
            rom[3]    = 16'h2345;
            rom[4]    = 16'h10A0;
            rom[9'h9F] = 16'h109F;
            rom[9'hA0] = 16'h3333;
            rom[9'h50] = 16'h0000;
        end else if (sel == 2) begin
            for (int i = 0; i < 512; i++) begin
                if (i >= 200) rom[i] = 16'h0000;
                else if (i < 190 && $urandom_range(7) == 0)
                    rom[i] = 16'h1000 | 16'(i + 1 + $urandom_range(7));
                else
                    rom[i] = {4'(2 + $urandom_range(13)), 12'($urandom)};
            end
        end
    endtask

    task automatic do_reset(input int sel, input logic rdy);
        RESET = 1'b1; BR_TAKEN = 1'b0; OUT_READY = 1'b0;
        tick();
        load_rom(sel);
        tick();
        RESET = 1'b0; OUT_READY = rdy;
    endtask

    task automatic test_reset();
        RESET = 1'b1; BR_TAKEN = 1'b0; OUT_READY = 1'b0;
        tick();
        load_rom(0);
        tick();
        total++; if (IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", IMEM_ADDR); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", HALT); end
        total++; if (ISSUE_COUNT !== 16'h0) begin bad++; $display("FAIL reset_count: got %h want 0000", ISSUE_COUNT); end
        RESET = 1'b0;
        tick();
        total++; if ({OUT_VALID, OUT_INSTR, OUT_PC} !== {1'b1, 16'hF008, 10'h000})
            begin bad++; $display("FAIL first_fetch: got v=%b i=%h pc=%h want v=1 i=f008 pc=000", OUT_VALID, OUT_INSTR, OUT_PC); end
        total++; if (OUT_RD !== 3'd1) begin bad++; $display("FAIL first_rd: got %0d want 1", OUT_RD); end
    endtask

    task automatic test_stream_backpressure();
        do_reset(0, 1'b1);
        total++; if (IMEM_ADDR !== 10'h000) begin bad++; $display("FAIL stream_a0: got %h want 000", IMEM_ADDR); end
        tick();
        total++; if (IMEM_ADDR !== 10'h002) begin bad++; $display("FAIL stream_a2: got %h want 002", IMEM_ADDR); end
        tick();
        total++; if (IMEM_ADDR !== 10'h004) begin bad++; $display("FAIL stream_a4: got %h want 004", IMEM_ADDR); end
        total++; if ({OUT_INSTR, OUT_IMM} !== {16'h5101, 16'h0001})
            begin bad++; $display("FAIL imm_pos: got i=%h imm=%h want 5101/0001", OUT_INSTR, OUT_IMM); end
        tick();
        total++; if (IMEM_ADDR !== 10'h006) begin bad++; $display("FAIL stream_a6: got %h want 006", IMEM_ADDR); end
        total++; if ({OUT_INSTR, OUT_PC, OUT_IMM} !== {16'h51FF, 10'h004, 16'hFFFF})
            begin bad++; $display("FAIL imm_neg: got i=%h pc=%h imm=%h want 51ff/004/ffff", OUT_INSTR, OUT_PC, OUT_IMM); end
        OUT_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if ({OUT_VALID, OUT_INSTR, OUT_PC, IMEM_ADDR, ISSUE_COUNT} !== {1'b1, 16'h51FF, 10'h004, 10'h006, 16'd2})
                begin bad++; $display("FAIL stall_%0d: got v=%b i=%h pc=%h a=%h c=%h want 1/51ff/004/006/0002", k, OUT_VALID, OUT_INSTR, OUT_PC, IMEM_ADDR, ISSUE_COUNT); end
        end
        OUT_READY = 1'b1;
        tick();
        total++; if ({OUT_INSTR, OUT_PC, ISSUE_COUNT} !== {16'h2345, 10'h006, 16'd3})
            begin bad++; $display("FAIL resume: got i=%h pc=%h c=%h want 2345/006/0003", OUT_INSTR, OUT_PC, ISSUE_COUNT); end
    endtask

    task automatic test_jump_fold();
        do_reset(0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (OUT_VALID === 1'b1 && OUT_INSTR === 16'h10A0)
                begin bad++; $display("FAIL jump_emitted: got i=%h want not 10a0", OUT_INSTR); end
            if (k == 3) begin
                total++; if ({OUT_PC, IMEM_ADDR} !== {10'h006, 10'h008})
                    begin bad++; $display("FAIL pre_jump: got pc=%h a=%h want 006/008", OUT_PC, IMEM_ADDR); end
            end
            if (k == 4) begin
                total++; if ({OUT_VALID, IMEM_ADDR} !== {1'b0, 10'h140})
                    begin bad++; $display("FAIL jump_bubble: got v=%b a=%h want 0/140", OUT_VALID, IMEM_ADDR); end
            end
            if (k == 5) begin
                total++; if ({OUT_VALID, OUT_INSTR, OUT_PC, IMEM_ADDR, ISSUE_COUNT} !== {1'b1, 16'h3333, 10'h140, 10'h142, 16'd4})
                    begin bad++; $display("FAIL jump_land: got v=%b i=%h pc=%h a=%h c=%h want 1/3333/140/142/0004", OUT_VALID, OUT_INSTR, OUT_PC, IMEM_ADDR, ISSUE_COUNT); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(0, 1'b0);
        tick();
        BR_TAKEN = 1'b1; BR_TARGET = 10'h041;
        tick();
        BR_TAKEN = 1'b0;
        total++; if ({OUT_VALID, IMEM_ADDR, ISSUE_COUNT} !== {1'b0, 10'h040, 16'd0})
            begin bad++; $display("FAIL redirect_flush: got v=%b a=%h c=%h want 0/040/0000", OUT_VALID, IMEM_ADDR, ISSUE_COUNT); end
        BR_TAKEN = 1'b1; BR_TARGET = 10'h006;
        tick();
        BR_TAKEN = 1'b0;
        tick();
        total++; if ({OUT_VALID, OUT_INSTR, IMEM_ADDR} !== {1'b1, 16'h2345, 10'h008})
            begin bad++; $display("FAIL redirect_fetch: got v=%b i=%h a=%h want 1/2345/008", OUT_VALID, OUT_INSTR, IMEM_ADDR); end
        OUT_READY = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 10'h020;
        tick();
        BR_TAKEN = 1'b0; OUT_READY = 1'b0;
        total++; if ({OUT_VALID, IMEM_ADDR, ISSUE_COUNT} !== {1'b0, 10'h020, 16'd1})
            begin bad++; $display("FAIL branch_vs_jump: got v=%b a=%h c=%h want 0/020/0001", OUT_VALID, IMEM_ADDR, ISSUE_COUNT); end
        tick();
        total++; if ({OUT_VALID, OUT_PC, OUT_INSTR} !== {1'b1, 10'h020, 16'h2010})
            begin bad++; $display("FAIL branch_land: got v=%b pc=%h i=%h want 1/020/2010", OUT_VALID, OUT_PC, OUT_INSTR); end
    endtask

    task automatic test_halt();
        do_reset(0, 1'b1);
        BR_TAKEN = 1'b1; BR_TARGET = 10'h13E;
        tick();
        BR_TAKEN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if ({HALT, IMEM_ADDR, OUT_VALID} !== {1'b1, 10'h13E, 1'b0})
                begin bad++; $display("FAIL self_jump_%0d: got h=%b a=%h v=%b want 1/13e/0", k, HALT, IMEM_ADDR, OUT_VALID); end
        end
        BR_TAKEN = 1'b1; BR_TARGET = 10'h0A0;
        tick();
        BR_TAKEN = 1'b0;
        total++; if ({HALT, IMEM_ADDR} !== {1'b0, 10'h0A0})
            begin bad++; $display("FAIL halt_clear: got h=%b a=%h want 0/0a0", HALT, IMEM_ADDR); end
        tick();
        total++; if ({HALT, IMEM_ADDR, OUT_VALID} !== {1'b1, 10'h0A0, 1'b0})
            begin bad++; $display("FAIL zero_halt: got h=%b a=%h v=%b want 1/0a0/0", HALT, IMEM_ADDR, OUT_VALID); end
        BR_TAKEN = 1'b1; BR_TARGET = 10'h000;
        tick();
        BR_TAKEN = 1'b0;
        tick();
        total++; if ({HALT, OUT_VALID, OUT_INSTR, IMEM_ADDR} !== {1'b0, 1'b1, 16'hF008, 10'h002})
            begin bad++; $display("FAIL resume_fetch: got h=%b v=%b i=%h a=%h want 0/1/f008/002", HALT, OUT_VALID, OUT_INSTR, IMEM_ADDR); end
    endtask

    task automatic test_random(input int iter);
        logic [15:0] exp_w [$];
        logic [9:0]  exp_pc [$];
        logic [15:0] w, hold_i;
        logic [9:0]  hold_pc;
        logic [31:0] exp_f;
        int idx, acc, imm;
        bit v, rdy, done;
        do_reset(2, 1'b0);
        // Walk the program as execute would see it: jumps followed, stop on 0000 or self-jump.
        idx = 0;
        for (int s = 0; s < 1000; s++) begin
            w = rom[idx];
            if (w[15:12] == 4'h1) begin
                if (int'(w[8:0]) == idx) break;
                idx = int'(w[8:0]);
            end else if (w[15:12] == 4'h0) begin
                break;
            end else begin
                exp_w.push_back(w);
                exp_pc.push_back(10'(idx * 2));
                idx = (idx + 1) % 512;
            end
        end
        acc = 0; done = 0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            rdy = ($urandom_range(3) != 0);
            OUT_READY = rdy;
            v = OUT_VALID;
            hold_i = OUT_INSTR; hold_pc = OUT_PC;
            if (v && rdy) begin
                acc++;
                if (exp_w.size() == 0) begin
                    total++; bad++; $display("FAIL rnd%0d_extra: got i=%h pc=%h want none", iter, OUT_INSTR, OUT_PC);
                end else begin
                    w = exp_w.pop_front();
                    total++; if ({OUT_INSTR, OUT_PC} !== {w, exp_pc.pop_front()})
                        begin bad++; $display("FAIL rnd%0d_instr: got i=%h pc=%h want i=%h", iter, OUT_INSTR, OUT_PC, w); end
                    imm = (w & 16'h3F);
                    if (w[5]) imm = imm - 64;
                    exp_f = {4'(w >> 12), 3'((w >> 9) & 7), 3'((w >> 6) & 7), 3'((w >> 3) & 7), 3'(w & 7), 16'(imm)};
                    total++; if ({OUT_OPCODE, OUT_RS, OUT_RT, OUT_RD, OUT_FUNCT, OUT_IMM} !== exp_f)
                        begin bad++; $display("FAIL rnd%0d_fields: got %h want %h", iter, {OUT_OPCODE, OUT_RS, OUT_RT, OUT_RD, OUT_FUNCT, OUT_IMM}, exp_f); end
                end
            end
            tick();
            if (v && !rdy) begin
                total++; if ({OUT_VALID, OUT_INSTR, OUT_PC} !== {1'b1, hold_i, hold_pc})
                    begin bad++; $display("FAIL rnd%0d_hold: got v=%b i=%h pc=%h want 1/%h/%h", iter, OUT_VALID, OUT_INSTR, OUT_PC, hold_i, hold_pc); end
            end
            if (HALT === 1'b1 && OUT_VALID === 1'b0) done = 1;
        end
        total++; if (!done) begin bad++; $display("FAIL rnd%0d_timeout: got halt=%b want 1", iter, HALT); end
        total++; if (exp_w.size() != 0) begin bad++; $display("FAIL rnd%0d_missing: got %0d left want 0", iter, exp_w.size()); end
        total++; if (ISSUE_COUNT !== 16'(acc)) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", iter, ISSUE_COUNT, acc); end
        OUT_READY = 1'b0;
    endtask

    task automatic test_wrap_saturation();
        do_reset(1, 1'b1);
        BR_TAKEN = 1'b1; BR_TARGET = 10'h3FE;
        tick();
        BR_TAKEN = 1'b0;
        total++; if (IMEM_ADDR !== 10'h3FE) begin bad++; $display("FAIL wrap_pre: got %h want 3fe", IMEM_ADDR); end
        tick();
        total++; if ({OUT_VALID, OUT_PC, IMEM_ADDR} !== {1'b1, 10'h3FE, 10'h000})
            begin bad++; $display("FAIL wrap: got v=%b pc=%h a=%h want 1/3fe/000", OUT_VALID, OUT_PC, IMEM_ADDR); end
        for (int k = 0; k < 65534; k++) tick();
        total++; if (ISSUE_COUNT !== 16'hFFFE) begin bad++; $display("FAIL count_fffe: got %h want fffe", ISSUE_COUNT); end
        tick();
        total++; if (ISSUE_COUNT !== 16'hFFFF) begin bad++; $display("FAIL count_ffff: got %h want ffff", ISSUE_COUNT); end
        for (int k = 0; k < 5; k++) tick();
        total++; if ({OUT_VALID, ISSUE_COUNT} !== {1'b1, 16'hFFFF})
            begin bad++; $display("FAIL count_sat: got v=%b c=%h want 1/ffff", OUT_VALID, ISSUE_COUNT); end
        OUT_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream_backpressure();
        test_jump_fold();
        test_redirect();
        test_halt();
        for (int it = 0; it < 3; it++) test_random(it);
        test_wrap_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
